// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the Y86-64 ALU arbiter slice:
//            ALU op encodings (Y86 ifun), jump/cmov condition encodings,
//            arbiter FSM state type and a condition-evaluation helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU operation select (matches Y86 OPq ifun)
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

  // Y86 condition function codes; codes 7..15 are not defined and evaluate false
  localparam logic [3:0] C_ALWAYS = 4'd0;
  localparam logic [3:0] C_LE     = 4'd1;
  localparam logic [3:0] C_L      = 4'd2;
  localparam logic [3:0] C_E      = 4'd3;
  localparam logic [3:0] C_NE     = 4'd4;
  localparam logic [3:0] C_GE     = 4'd5;
  localparam logic [3:0] C_G      = 4'd6;

  // Arbiter state: one op in flight, accept -> execute -> respond
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Evaluate a Y86 condition against the condition codes
  function automatic logic cond_eval(input logic [3:0] fn,
                                     input logic       zf,
                                     input logic       sf,
                                     input logic       of);
    logic lt;
    lt = sf ^ of;
    case (fn)
      C_ALWAYS: cond_eval = 1'b1;
      C_LE:     cond_eval = lt | zf;
      C_L:      cond_eval = lt;
      C_E:      cond_eval = zf;
      C_NE:     cond_eval = ~zf;
      C_GE:     cond_eval = ~lt;
      C_G:      cond_eval = ~lt & ~zf;
      default:  cond_eval = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu64_core.sv
`default_nettype none
// ============================================================================
// Module   : alu64_core
// Purpose  : Combinational Y86-64 ALU: ADD (b+a), SUB (b-a), AND, XOR,
//            with zero / sign / signed-overflow flags.
// Ports    : i_op [1:0]  operation select (ALU_ADD..ALU_XOR)
//            i_a  [W-1:0] operand A
//            i_b  [W-1:0] operand B
//            o_result [W-1:0], o_zf, o_sf, o_of
// Revision : 1.0 - initial release
// ============================================================================
module alu64_core
  import alu_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [1:0]   i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_result,
  output logic         o_zf,
  output logic         o_sf,
  output logic         o_of
);

  logic [W-1:0] w_res;
  logic         w_of;

  always_comb begin
    w_res = '0;
    w_of  = 1'b0;
    case (i_op)
      ALU_ADD: begin
        w_res = i_b + i_a;
        // like-signed operands producing an opposite-signed sum
        w_of  = (i_a[W-1] == i_b[W-1]) && (w_res[W-1] != i_a[W-1]);
      end
      ALU_SUB: begin
        // Y86 subtracts A from B; overflow when signs differ and the
        // result sign departs from the minuend B
        w_res = i_b - i_a;
        w_of  = (i_a[W-1] != i_b[W-1]) && (w_res[W-1] != i_b[W-1]);
      end
      ALU_AND: w_res = i_a & i_b;
      default: w_res = i_a ^ i_b;
    endcase
  end

  assign o_result = w_res;
  assign o_zf     = (w_res == '0);
  assign o_sf     = w_res[W-1];
  assign o_of     = w_of;

endmodule
`default_nettype wire

// File: rtl/alu_arbiter_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_seq
// Purpose  : Shares one Y86-64 ALU between the execute stage (req0) and
//            address calculation (req1). Round-robin grant, one op in
//            flight, registered result with valid/ready response, and the
//            architectural CC register (ZF/SF/OF), updated by req0 only.
// Ports    : clk, rst (sync, active-high)
//            req0_valid/ready/op/a/b/setcc : execute-stage request
//            req1_valid/ready/op/a/b       : address-calc request
//            rsp_valid/ready/id/result     : response channel
//            cc_zf, cc_sf, cc_of           : CC register
//            cnd_fn [3:0] in, cnd out      : condition on current CC
// Config   : ALU_ARB_CND_EN - when defined, cnd is evaluated from cnd_fn
//            and the CC register; otherwise cnd is tied high.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter_seq
  import alu_pkg::*;
#(
  parameter int   W       = 64,
  parameter logic RR_INIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_setcc,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of,
  input  logic [3:0]   cnd_fn,
  output logic         cnd
);

  state_t       r_state, w_state_nxt;
  logic         r_rr;          // requester favoured on a tie
  logic [1:0]   r_op;
  logic [W-1:0] r_a, r_b;
  logic         r_id;
  logic         r_setcc;
  logic         r_rsp_id;
  logic [W-1:0] r_rsp_result;
  logic         r_zf, r_sf, r_of;

  logic         w_gnt0, w_gnt1;
  logic [W-1:0] w_res;
  logic         w_zf, w_sf, w_of;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state and grants ----------------
  always_comb begin
    w_state_nxt = r_state;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // lone requester wins; on a tie the rr pointer decides
        w_gnt0 = req0_valid & (~req1_valid | ~r_rr);
        w_gnt1 = req1_valid & (~req0_valid |  r_rr);
        if (w_gnt0 | w_gnt1) w_state_nxt = S_EXEC;
      end
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // nothing may be accepted while reset is asserted
    if (rst) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign rsp_valid  = (r_state == S_RESP);

  // ---------------- shared ALU ----------------
  alu64_core #(.W(W)) u_alu (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_res),
    .o_zf     (w_zf),
    .o_sf     (w_sf),
    .o_of     (w_of)
  );

  // ---------------- datapath / CC register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr         <= RR_INIT;
      r_op         <= ALU_ADD;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_setcc      <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_zf         <= 1'b1;
      r_sf         <= 1'b0;
      r_of         <= 1'b0;
    end else begin
      if (w_gnt0 | w_gnt1) begin
        r_op    <= w_gnt1 ? req1_op : req0_op;
        r_a     <= w_gnt1 ? req1_a  : req0_a;
        r_b     <= w_gnt1 ? req1_b  : req0_b;
        r_id    <= w_gnt1;
        r_setcc <= w_gnt0 & req0_setcc;  // address calc never touches CC
        r_rr    <= ~w_gnt1;              // favour the other side next time
      end
      if (r_state == S_EXEC) begin
        r_rsp_result <= w_res;
        r_rsp_id     <= r_id;
        if (~r_id & r_setcc) begin
          r_zf <= w_zf;
          r_sf <= w_sf;
          r_of <= w_of;
        end
      end
    end
  end

  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign cc_zf      = r_zf;
  assign cc_sf      = r_sf;
  assign cc_of      = r_of;

`ifdef ALU_ARB_CND_EN
  assign cnd = cond_eval(cnd_fn, r_zf, r_sf, r_of);
`else
  logic w_unused_cnd_fn;
  assign w_unused_cnd_fn = ^cnd_fn;
  assign cnd             = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter_seq
// Purpose  : Self-checking bench for alu_arbiter_seq: directed vector table,
//            multi-cycle corner sequences (alternating grants, response
//            back-pressure, reset during execute) and randomized traffic
//            against a behavioural reference model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter_seq;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_setcc;
  logic [1:0]   req0_op;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready;
  logic [1:0]   req1_op;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_result;
  logic         cc_zf, cc_sf, cc_of;
  logic [3:0]   cnd_fn;
  logic         cnd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter_seq #(.W(W), .RR_INIT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_setcc(req0_setcc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
    .cnd_fn(cnd_fn), .cnd(cnd)
  );

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        setcc;
    logic [3:0]  fn;
    logic [63:0] res;
    logic        zf, sf, of;
    logic        cnd_on;   // expected cnd when the condition feature is built in
  } vec_t;

  vec_t vecs [9];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  // Y86 condition semantics in terms of signed comparison outcomes
  function automatic logic exp_cnd(input logic [3:0] fn, input logic zf, input logic sf, input logic of);
`ifdef ALU_ARB_CND_EN
    logic less;
    less = (sf != of);
    case (fn)
      4'd0: return 1'b1;
      4'd1: return less || zf;
      4'd2: return less;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !less;
      4'd6: return !less && !zf;
      default: return 1'b0;
    endcase
`else
    return (fn == fn);
`endif
  endfunction

  // Reference ALU: exact signed arithmetic decides overflow
  function automatic void ref_alu(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic zf, output logic sf, output logic of);
    logic signed [65:0] sa, sb, exact, smax, smin;
    sa   = $signed({{2{a[63]}}, a});
    sb   = $signed({{2{b[63]}}, b});
    smax = (66'sd1 <<< 63) - 66'sd1;
    smin = -(66'sd1 <<< 63);
    of   = 1'b0;
    case (op)
      2'd0: begin exact = sb + sa; r = b + a; of = (exact > smax) || (exact < smin); end
      2'd1: begin exact = sb - sa; r = b - a; of = (exact > smax) || (exact < smin); end
      2'd2: r = a & b;
      default: r = a ^ b;
    endcase
    zf = (r == 64'd0);
    sf = r[63];
  endfunction

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 4))
      0: return 64'h7FFF_FFFF_FFFF_FFFF;
      1: return 64'h8000_0000_0000_0000;
      2: return 64'($urandom_range(0, 7));
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic drive_req(input logic id, input logic [1:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic setcc);
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_setcc = setcc;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // waits (bounded) for the given requester to be accepted, sampling at negedge
  task automatic wait_accept(input string name, input logic id);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) got = 1'b1;
    end
    check1(name, got, 1'b1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    cnd_fn    = v.fn;
    drive_req(v.id, v.op, v.a, v.b, v.setcc);
    wait_accept({tag, "_accept"}, v.id);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check1({tag, "_early_valid"}, rsp_valid, 1'b0);
    @(negedge clk);
    check1({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    check64({tag, "_result"}, rsp_result, v.res);
    check1({tag, "_id"}, rsp_id, v.id);
    check1({tag, "_zf"}, cc_zf, v.zf);
    check1({tag, "_sf"}, cc_sf, v.sf);
    check1({tag, "_of"}, cc_of, v.of);
    check1({tag, "_cnd"}, cnd, exp_cnd(v.fn, v.zf, v.sf, v.of) & (v.cnd_on | (v.fn == v.fn && !cnd_feature())));
  endtask

  function automatic logic cnd_feature();
`ifdef ALU_ARB_CND_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        grants[$];
    logic        m_busy, m_id, m_setcc, m_rr, m_zf, m_sf, m_of;
    logic        p_zf, p_sf, p_of, g0, g1, exp_rv;
    logic [63:0] m_res;
    int          m_age;

    //                 id    op    a                        b                        sc    fn    res                      zf    sf    of    cnd
    vecs[0] = '{1'b0, 2'd0, 64'd3,                   64'd5,                   1'b1, 4'd0, 64'd8,                   1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 2'd1, 64'd5,                   64'd5,                   1'b1, 4'd3, 64'd0,                   1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 4'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 2'd1, 64'd1,                   64'd0,                   1'b1, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 2'd2, 64'hF0F0,                64'h0FF0,                1'b1, 4'd6, 64'h00F0,                1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 2'd3, 64'hAAAA,                64'hAAAA,                1'b1, 4'd4, 64'd0,                   1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 2'd3, 64'd1,                   64'd2,                   1'b1, 4'd7, 64'd3,                   1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 2'd1, 64'h8000_0000_0000_0000, 64'd0,                   1'b1, 4'd5, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 2'd0, 64'd1,                   64'd1,                   1'b0, 4'd1, 64'd2,                   1'b0, 1'b1, 1'b1, 1'b0};

    // ---------- reset state, requests pending during reset ----------
    rst = 1'b1; rsp_ready = 1'b0; cnd_fn = 4'd0;
    req0_valid = 1'b1; req0_op = 2'd0; req0_a = 64'd1; req0_b = 64'd1; req0_setcc = 1'b1;
    req1_valid = 1'b1; req1_op = 2'd0; req1_a = 64'd1; req1_b = 64'd1;
    repeat (2) @(negedge clk);
    check1("rst_ready0", req0_ready, 1'b0);
    check1("rst_ready1", req1_ready, 1'b0);
    check1("rst_rsp_valid", rsp_valid, 1'b0);
    check1("rst_rsp_id", rsp_id, 1'b0);
    check64("rst_result", rsp_result, 64'd0);
    check1("rst_zf", cc_zf, 1'b1);
    check1("rst_sf", cc_sf, 1'b0);
    check1("rst_of", cc_of, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

    // ---------- directed vector table ----------
    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // ---------- both requesters always valid: alternating grants ----------
    do_reset();
    rsp_ready = 1'b1;
    drive_req(1'b0, 2'd2, 64'hFF, 64'h0F, 1'b1);  // AND -> 0x0F, CC 000
    drive_req(1'b1, 2'd3, 64'd5, 64'd5, 1'b0);    // XOR -> 0, must not set ZF
    for (int i = 0; i < 60 && grants.size() < 4; i++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) check1("alt_one_ready", 1'b1, 1'b0);
      else if (req0_ready) grants.push_back(1'b0);
      else if (req1_ready) grants.push_back(1'b1);
    end
    check64("alt_grant_count", 64'(grants.size()), 64'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      check1($sformatf("alt_grant%0d", i), grants[i], logic'(i % 2));
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    check1("alt_cc_zf", cc_zf, 1'b0);
    check1("alt_cc_sf", cc_sf, 1'b0);
    check1("alt_cc_of", cc_of, 1'b0);

    // ---------- response back-pressure ----------
    repeat (2) @(posedge clk);
    #1 rsp_ready = 1'b0;
    drive_req(1'b0, 2'd0, 64'd10, 64'd20, 1'b0);
    wait_accept("bp_accept", 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drive_req(1'b1, 2'd3, 64'd6, 64'd3, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check1($sformatf("bp_valid%0d", i), rsp_valid, 1'b1);
      check64($sformatf("bp_result%0d", i), rsp_result, 64'd30);
      check1($sformatf("bp_id%0d", i), rsp_id, 1'b0);
      check1($sformatf("bp_ready0_%0d", i), req0_ready, 1'b0);
      check1($sformatf("bp_ready1_%0d", i), req1_ready, 1'b0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    check1("bp_hs_ready1", req1_ready, 1'b0);
    @(negedge clk);
    check1("bp_next_ready1", req1_ready, 1'b1);
    @(posedge clk); #1 req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    check1("bp_r1_valid", rsp_valid, 1'b1);
    check64("bp_r1_result", rsp_result, 64'd5);
    check1("bp_r1_id", rsp_id, 1'b1);

    // ---------- reset while executing ----------
    run_vec(0, vecs[0]);                            // CC 000
    @(posedge clk); #1;
    drive_req(1'b0, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    wait_accept("rx_accept", 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check1("rx_exec_valid", rsp_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_req(1'b1, 2'd3, 64'd1, 64'd1, 1'b0);
    @(negedge clk);
    check1("rx_no_rsp", rsp_valid, 1'b0);
    check1("rx_zf", cc_zf, 1'b1);
    check1("rx_sf", cc_sf, 1'b0);
    check1("rx_of", cc_of, 1'b0);
    check1("rx_idle_ready1", req1_ready, 1'b1);
    @(posedge clk); #1 req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    check1("rx_r1_valid", rsp_valid, 1'b1);
    check64("rx_r1_result", rsp_result, 64'd0);
    check1("rx_r1_id", rsp_id, 1'b1);
    check1("rx_r1_zf", cc_zf, 1'b1);

    // ---------- randomized traffic vs reference model ----------
    do_reset();
    m_busy = 1'b0; m_id = 1'b0; m_setcc = 1'b0; m_rr = 1'b0; m_age = 0;
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0; m_res = 64'd0;
    p_zf = 1'b0; p_sf = 1'b0; p_of = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (m_busy) begin
        m_age++;
        if (m_age == 2 && !m_id && m_setcc) begin
          m_zf = p_zf; m_sf = p_sf; m_of = p_of;
        end
      end
      exp_rv = m_busy && (m_age >= 2);
      g0 = !m_busy && req0_valid && (!req1_valid || !m_rr);
      g1 = !m_busy && req1_valid && (!req0_valid ||  m_rr);
      check1("rnd_ready0", req0_ready, g0);
      check1("rnd_ready1", req1_ready, g1);
      check1("rnd_rsp_valid", rsp_valid, exp_rv);
      if (exp_rv) begin
        check1("rnd_rsp_id", rsp_id, m_id);
        check64("rnd_rsp_result", rsp_result, m_res);
      end
      check64("rnd_cc", {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, m_zf, m_sf, m_of});
      check1("rnd_cnd", cnd, exp_cnd(cnd_fn, m_zf, m_sf, m_of));
      if (exp_rv && rsp_ready) m_busy = 1'b0;
      if (g0 || g1) begin
        m_busy  = 1'b1;
        m_age   = 0;
        m_id    = g1;
        m_setcc = g0 && req0_setcc;
        m_rr    = !g1;
        if (g1) ref_alu(req1_op, req1_a, req1_b, m_res, p_zf, p_sf, p_of);
        else    ref_alu(req0_op, req0_a, req0_b, m_res, p_zf, p_sf, p_of);
      end
      @(posedge clk); #1;
      if (g0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_op    = 2'($urandom_range(0, 3));
        req0_a     = pick_operand();
        req0_b     = pick_operand();
        req0_setcc = 1'($urandom_range(0, 1));
      end
      if (g1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_op    = 2'($urandom_range(0, 3));
        req1_a     = pick_operand();
        req1_b     = pick_operand();
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      cnd_fn    = 4'($urandom_range(0, 15));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
